// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads program memory, fills the IF/ID register.
// Optional HALT_DETECT_EN: an all-ones instruction word parks the fetcher in HALT until a branch.
module fetch_sequencer #(
  parameter int unsigned   AW       = 4,
  parameter int unsigned   IW       = 9,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [IW-1:0] NOP      = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] pmem_addr,
  input  logic [IW-1:0] pmem_instr,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [IW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  output logic          if_valid,
  output logic          halted,
  output logic [7:0]    fetch_cnt
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    pc_q;
  logic [IW-1:0]    instr_q;
  logic [AW-1:0]    ipc_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  // Fetch FSM: branch beats stall beats normal fetch; HALT only leaves on a branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (br_taken) begin
            pc_q    <= br_target;
            instr_q <= NOP;
            valid_q <= 1'b0;
          end else if (!stall) begin
`ifdef HALT_DETECT_EN
            if (pmem_instr == {IW{1'b1}}) begin
              instr_q <= NOP;
              valid_q <= 1'b0;
              state_q <= ST_HALT;
            end else
`endif
            begin
              instr_q <= pmem_instr;
              ipc_q   <= pc_q;
              valid_q <= 1'b1;
              pc_q    <= pc_q + AW'(1);
              if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
        end
        ST_HALT: begin
          instr_q <= NOP;
          valid_q <= 1'b0;
          if (br_taken) begin
            pc_q    <= br_target;
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign pmem_addr = pc_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;
  assign if_valid  = valid_q;
  assign fetch_cnt = cnt_q;
`ifdef HALT_DETECT_EN
  assign halted    = (state_q == ST_HALT);
`else
  assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random stall/branch/reset traffic vs a reference model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst, stall, br_taken;
  logic [3:0] br_target, pmem_addr, if_pc;
  logic [8:0] pmem_instr, if_instr;
  logic       if_valid, halted;
  logic [7:0] fetch_cnt;

  logic [8:0] mem [16];

  int n_chk = 0;
  int n_bad = 0;

`ifdef HALT_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  // Reference state, tracked as plain integers.
  int  m_pc, m_ipc, m_instr, m_cnt;
  bit  m_valid, m_halt, addr_known;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .pmem_addr  (pmem_addr),
    .pmem_instr (pmem_instr),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .halted     (halted),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;
  assign pmem_instr = mem[pmem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the architectural rules, then compare.
  task automatic step(input bit r, input bit s, input bit b, input int t);
    int w;
    @(negedge clk);
    if (addr_known) check("pmem_addr_pre", 32'(pmem_addr), 32'(m_pc));
    rst = r; stall = s; br_taken = b; br_target = 4'(t);
    if (r) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halt = 0; m_cnt = 0;
    end else if (m_halt) begin
      m_instr = 0; m_valid = 0;
      if (b) begin m_pc = t; m_halt = 0; end
    end else if (b) begin
      m_pc = t; m_instr = 0; m_valid = 0;
    end else if (!s) begin
      w = int'(mem[m_pc]);
      if (HD && w == 511) begin
        m_instr = 0; m_valid = 0; m_halt = 1;
      end else begin
        m_instr = w; m_ipc = m_pc; m_valid = 1;
        m_pc = (m_pc + 1) % 16;
        m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    addr_known = 1'b1;
    check("pmem_addr", 32'(pmem_addr), 32'(m_pc));
    check("if_instr",  32'(if_instr),  32'(m_instr));
    check("if_pc",     32'(if_pc),     32'(m_ipc));
    check("if_valid",  32'(if_valid),  32'(m_valid));
    check("halted",    32'(halted),    32'(m_halt));
    check("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    addr_known = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 9'(i + 16);

    // Reset, then free-run: words 010..013 appear in order.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("t1_instr", 32'(if_instr), 32'h013);
    check("t1_pc",    32'(if_pc),    32'd3);
    check("t1_cnt",   32'(fetch_cnt), 32'd4);

    // Stall at pc=4 for three cycles, then release.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("t2_addr", 32'(pmem_addr), 32'd4);
    step(0, 0, 0, 0);
    check("t2_instr", 32'(if_instr), 32'h014);
    check("t2_addr_after", 32'(pmem_addr), 32'd5);

    // Branch with simultaneous stall from pc=6: one bubble then target word.
    step(0, 0, 0, 0);
    step(0, 1, 1, 2);
    check("t3_valid", 32'(if_valid), 32'd0);
    check("t3_addr",  32'(pmem_addr), 32'd2);
    step(0, 0, 0, 0);
    check("t3_instr", 32'(if_instr), 32'h012);
    check("t3_pc",    32'(if_pc), 32'd2);

    // Wrap-around from 14.
    step(0, 0, 1, 14);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("t4_pc_wrap", 32'(if_pc), 32'd1);

    // All-ones word at address 3.
    mem[3] = 9'h1FF;
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    if (HD) begin
      for (int i = 0; i < 4; i++) step(0, i == 1, 0, 0);
      check("t5_halted", 32'(halted), 32'd1);
      check("t5_addr",   32'(pmem_addr), 32'd3);
      step(0, 0, 1, 0);
      check("t5_resume", 32'(halted), 32'd0);
      step(0, 0, 0, 0);
      check("t5_word0", 32'(if_instr), 32'h010);
    end else begin
      check("t5_plain_word", 32'(if_instr), 32'h1FF);
      check("t5_plain_valid", 32'(if_valid), 32'd1);
    end

    // Reset while stalled (and halted in the detect build).
    step(0, 0, 1, 3);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    check("t6_cnt",  32'(fetch_cnt), 32'd0);
    check("t6_addr", 32'(pmem_addr), 32'd0);

    // Saturation of the delivered-instruction counter.
    for (int i = 0; i < 16; i++) mem[i] = 9'(i * 7 + 1);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0);
    check("cnt_sat", 32'(fetch_cnt), 32'hFF);

    // Random traffic, including all-ones words and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        mem[$urandom_range(0, 15)] = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
